fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 Parameter: OP_HALT, 4'hC, opcode that stops the sequencer.
REQ-003 Clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high; clock Clk.
REQ-005 run  input  1  level; 1 = sequencer may fetch, 0 = stop at next instruction boundary.
REQ-006 resume  input  1  single-cycle pulse; leaves HALT.
REQ-007 instr  input  4  opcode nibble from fetch register (high nibble).
REQ-008 oprnd  input  4  operand nibble from fetch register (low nibble).
REQ-009 rom_data  input  8  combinational ROM output at current PC.
REQ-010 c_flag, z_flag  input  1 each  ALU carry/zero flags.
REQ-011 exec_ready  input  1  datapath accepts the presented instruction.
REQ-012 pc_inc  output  1  PC counter increment enable.
REQ-013 pc_load  output  1  PC counter load strobe.
REQ-014 load_addr  output  12  PC load value.
REQ-015 fetch_en  output  1  fetch-register enable.
REQ-016 exec_valid  output  1  instruction presented to datapath.
REQ-017 exec_op, exec_arg  output  4 each  opcode/operand presented.
REQ-018 halted  output  1  high while in HALT.
REQ-019 state  output  3  FSM encoding: IDLE=0, FETCH=1, DECODE=2, BRANCH=3, HALT=4.
REQ-020 retired  output  CNT_W  completed-instruction count.

Function
REQ-021 Opcodes: 4'hF JMP, 4'hE JC, 4'hD JZ, OP_HALT HALT; all others are execute-class.
REQ-022 IDLE: all strobes 0; go to FETCH when run=1.
REQ-023 FETCH (one cycle): fetch_en=1, pc_inc=1; next DECODE.
REQ-024 DECODE, execute-class: exec_valid=1, exec_op=instr, exec_arg=oprnd, held stable until cycle with exec_ready=1; that cycle retires the instruction and exits.
REQ-025 DECODE, branch-class (JMP/JC/JZ): no exec_valid; next BRANCH.
REQ-026 DECODE, HALT: retire, next HALT.
REQ-027 BRANCH (one cycle): target = {oprnd, rom_data}; taken if JMP, JC with c_flag=1, or JZ with z_flag=1, flags sampled this cycle.
REQ-028 BRANCH taken: pc_load=1, load_addr=target; not taken: pc_inc=1 (skips address byte); retire either way.
REQ-029 pc_inc and pc_load SHALL never be 1 in the same cycle; load_addr=0 when pc_load=0.
REQ-030 After retirement: run=1 -> FETCH, run=0 -> IDLE; run deassertion mid-instruction never aborts the instruction.
REQ-031 HALT: halted=1, no strobes; resume=1 -> FETCH if run=1 else IDLE; resume outside HALT ignored.
REQ-032 retired increments by 1 per retirement, wraps 2^CNT_W-1 -> 0.
REQ-033 Execute-class throughput: 2 cycles per instruction with exec_ready tied 1; branches 3 cycles.
REQ-034 Unused state encodings SHALL recover to IDLE next cycle.

Reset
REQ-035 reset=1 forces state=IDLE, retired=0, all strobe/data outputs 0, halted=0, immediately and independent of Clk.
REQ-036 reset asserted mid-DECODE or mid-BRANCH abandons the instruction with no pc_load/pc_inc and no retirement.

Verification
REQ-037 run=1, ROM[0]=8'h23, exec_ready=1 -> fetch_en/pc_inc cycle 1, exec_valid with op=2 arg=3 cycle 2, retired=1.
REQ-038 ROM[0]=8'hF4, ROM[1]=8'h56 -> BRANCH cycle pc_load=1, load_addr=12'h456, pc_inc=0.
REQ-039 ROM[0]=8'hE1, ROM[1]=8'h00, c_flag=0 -> pc_inc=1, pc_load=0; repeat with c_flag=1 -> load_addr=12'h100.
REQ-040 exec_ready held 0 for 5 cycles -> exec_valid/op/arg stable 5 cycles, no fetch_en, retired unchanged until ready.
REQ-041 ROM[0]=8'hC0 -> halted=1, no strobes for 10 cycles; resume pulse with run=1 -> FETCH next cycle.
REQ-042 retired preset path: 2^CNT_W retirements -> retired wraps to 0; reset asserted during BRANCH -> outputs 0 asynchronously, no pc_load.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction sequencer for a nibble-opcode machine: fetch, decode, branch resolution and halt.
// Strobes are decoded from the state register so the handshake and branch flags act in the same cycle.
module fetch_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [3:0]  OP_HALT = 4'hC
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             run,
  input  logic             resume,
  input  logic [3:0]       instr,
  input  logic [3:0]       oprnd,
  input  logic [7:0]       rom_data,
  input  logic             c_flag,
  input  logic             z_flag,
  input  logic             exec_ready,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [11:0]      load_addr,
  output logic             fetch_en,
  output logic             exec_valid,
  output logic [3:0]       exec_op,
  output logic [3:0]       exec_arg,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] OP_JMP = 4'hF;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_JZ  = 4'hD;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_BRANCH = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   retire;
  logic   is_branch;
  logic   taken;
  state_t after_retire;

  assign state        = state_q;
  assign is_branch    = (instr == OP_JMP) || (instr == OP_JC) || (instr == OP_JZ);
  assign taken        = (instr == OP_JMP) || ((instr == OP_JC) && c_flag) ||
                        ((instr == OP_JZ) && z_flag);
  assign after_retire = run ? S_FETCH : S_IDLE;

  // Next-state and strobe decode; an instruction in flight always completes.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    load_addr  = 12'h000;
    fetch_en   = 1'b0;
    exec_valid = 1'b0;
    exec_op    = 4'h0;
    exec_arg   = 4'h0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        fetch_en = 1'b1;
        pc_inc   = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (instr == OP_HALT) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else if (is_branch) begin
          state_d = S_BRANCH;
        end else begin
          exec_valid = 1'b1;
          exec_op    = instr;
          exec_arg   = oprnd;
          if (exec_ready) begin
            retire  = 1'b1;
            state_d = after_retire;
          end
        end
      end
      S_BRANCH: begin
        // Not-taken still bumps the PC past the address byte.
        if (taken) begin
          pc_load   = 1'b1;
          load_addr = {oprnd, rom_data};
        end else begin
          pc_inc = 1'b1;
        end
        retire  = 1'b1;
        state_d = after_retire;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_d = after_retire;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and retired-instruction counter.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small PC / ROM / fetch-register environment around it.
module tb_fetch_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             Clk = 1'b0;
  logic             reset;
  logic             run, resume, c_flag, z_flag, exec_ready;
  logic [3:0]       instr, oprnd;
  logic [7:0]       rom_data;
  logic             pc_inc, pc_load, fetch_en, exec_valid, halted;
  logic [11:0]      load_addr;
  logic [3:0]       exec_op, exec_arg;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  logic [7:0]  rom [0:4095];
  logic [11:0] pc;
  logic [7:0]  fetch_reg;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_ctrl #(.CNT_W(CNT_W), .OP_HALT(4'hC)) dut (
    .Clk(Clk), .reset(reset), .run(run), .resume(resume),
    .instr(instr), .oprnd(oprnd), .rom_data(rom_data),
    .c_flag(c_flag), .z_flag(z_flag), .exec_ready(exec_ready),
    .pc_inc(pc_inc), .pc_load(pc_load), .load_addr(load_addr),
    .fetch_en(fetch_en), .exec_valid(exec_valid), .exec_op(exec_op),
    .exec_arg(exec_arg), .halted(halted), .state(state), .retired(retired)
  );

  always #5 Clk = ~Clk;

  assign rom_data = rom[pc];
  assign instr    = fetch_reg[7:4];
  assign oprnd    = fetch_reg[3:0];

  // Environment: PC counter and fetch register driven by the DUT strobes.
  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      pc        <= 12'h000;
      fetch_reg <= 8'h00;
    end else begin
      if (pc_load)     pc <= load_addr;
      else if (pc_inc) pc <= pc + 12'h001;
      if (fetch_en) fetch_reg <= rom_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 4096; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; resume = 1'b0;
    c_flag = 1'b0; z_flag = 1'b0; exec_ready = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] strobes();
    return 32'({fetch_en, pc_inc, pc_load, exec_valid, halted});
  endfunction

  initial begin
    fill_rom(8'h00);
    reset = 1'b1; run = 1'b1; resume = 1'b0;
    c_flag = 1'b0; z_flag = 1'b0; exec_ready = 1'b1;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_strobes", strobes(), 32'd0);
    chk("rst_data", 32'({load_addr, exec_op, exec_arg}), 32'd0);

    // Single execute-class instruction 0x23
    rom[0] = 8'h23;
    do_reset();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_ignored", 32'(state), 32'd0);
    run = 1'b1; #1;
    chk("idle_no_fetch", strobes(), 32'd0);
    tick();
    chk("t1_fetch_state", 32'(state), 32'd1);
    chk("t1_fetch_strobes", strobes(), 32'b11000);
    tick();
    chk("t1_decode_state", 32'(state), 32'd2);
    chk("t1_exec_valid", 32'(exec_valid), 32'd1);
    chk("t1_exec_op_arg", 32'({exec_op, exec_arg}), 32'h23);
    run = 1'b0;
    tick();
    chk("t1_idle", 32'(state), 32'd0);
    chk("t1_retired", 32'(retired), 32'd1);
    chk("t1_pc", 32'(pc), 32'd1);

    // JMP 0x456
    fill_rom(8'h00); rom[0] = 8'hF4; rom[1] = 8'h56;
    do_reset();
    run = 1'b1;
    tick(); tick();
    chk("jmp_decode_no_valid", 32'({state, exec_valid}), 32'({3'd2, 1'b0}));
    run = 1'b0;
    tick();
    chk("jmp_branch_state", 32'(state), 32'd3);
    chk("jmp_pc_load", 32'({pc_load, pc_inc}), 32'b10);
    chk("jmp_load_addr", 32'(load_addr), 32'h456);
    tick();
    chk("jmp_pc", 32'(pc), 32'h456);
    chk("jmp_retired", 32'(retired), 32'd1);

    // JC not taken then taken
    fill_rom(8'h00); rom[0] = 8'hE1; rom[1] = 8'h00;
    do_reset();
    run = 1'b1;
    tick(); tick(); tick();
    chk("jc_nt_strobes", 32'({pc_inc, pc_load}), 32'b10);
    chk("jc_nt_addr", 32'(load_addr), 32'd0);
    run = 1'b0;
    tick();
    chk("jc_nt_pc", 32'(pc), 32'd2);
    chk("jc_nt_retired", 32'(retired), 32'd1);
    do_reset();
    c_flag = 1'b1; run = 1'b1;
    tick(); tick(); tick();
    chk("jc_t_strobes", 32'({pc_inc, pc_load}), 32'b01);
    chk("jc_t_addr", 32'(load_addr), 32'h100);

    // JZ taken on z_flag
    fill_rom(8'h00); rom[0] = 8'hD2; rom[1] = 8'h34;
    do_reset();
    z_flag = 1'b1; run = 1'b1;
    tick(); tick(); tick();
    chk("jz_t_addr", 32'({pc_load, load_addr}), 32'h1234);

    // exec_ready stall with run dropped mid-instruction
    fill_rom(8'h00); rom[0] = 8'h57;
    do_reset();
    exec_ready = 1'b0; run = 1'b1;
    tick(); tick();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_outputs", 32'({state, exec_valid, fetch_en, exec_op, exec_arg}),
          32'({3'd2, 1'b1, 1'b0, 8'h57}));
      chk("stall_retired", 32'(retired), 32'd0);
      tick();
    end
    exec_ready = 1'b1; #1;
    chk("stall_release", 32'({exec_valid, exec_op, exec_arg}), 32'h157);
    tick();
    chk("stall_idle", 32'(state), 32'd0);
    chk("stall_retired_done", 32'(retired), 32'd1);

    // HALT, resume and back-to-back throughput
    fill_rom(8'h00); rom[0] = 8'hC0; rom[1] = 8'h23;
    do_reset();
    run = 1'b1;
    tick(); tick();
    chk("halt_decode_no_valid", 32'(exec_valid), 32'd0);
    tick();
    chk("halt_state", 32'(state), 32'd4);
    chk("halt_retired", 32'(retired), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("halt_hold", strobes(), 32'b00001);
      tick();
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_fetch", 32'({state, halted}), 32'({3'd1, 1'b0}));
    tick();
    chk("resume_decode", 32'({state, exec_op, exec_arg}), 32'({3'd2, 8'h23}));
    tick();
    chk("thru_refetch", 32'(state), 32'd1);
    chk("thru_retired", 32'(retired), 32'd2);

    // Retired counter wrap at 2^CNT_W
    fill_rom(8'h11);
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    chk("wrap_pre", 32'(retired), 32'd15);
    tick(); tick();
    chk("wrap_zero", 32'(retired), 32'd0);

    // Reset asserted during BRANCH
    fill_rom(8'h00); rom[0] = 8'hF4; rom[1] = 8'h56;
    do_reset();
    run = 1'b1;
    tick(); tick(); tick();
    chk("rb_branch_load", 32'(pc_load), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rb_state", 32'(state), 32'd0);
    chk("rb_outputs", 32'({pc_load, pc_inc, load_addr}), 32'd0);
    chk("rb_retired", 32'(retired), 32'd0);
    tick();
    reset = 1'b0;
    chk("rb_pc", 32'(pc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
